// File: rtl/delay_measurer.sv
// delay_measurer: measures the cycles from a start pulse to a stop pulse.
// It returns each result over a valid/ready handshake and keeps running
// min/max/count statistics over the measurements that did not time out.
module delay_measurer #(
  parameter int unsigned BW_COUNT      = 32,
  parameter int unsigned TIMEOUT_COUNT = 0,
  parameter int unsigned BW_NUM        = 16
) (
  input  logic                clk,
  input  logic                rstnn,
  input  logic                start,
  input  logic                stop,
  input  logic                clear,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [BW_COUNT-1:0] result_delay,
  output logic                result_timeout,
  output logic [BW_COUNT-1:0] min_delay,
  output logic [BW_COUNT-1:0] max_delay,
  output logic [BW_NUM-1:0]   num_measure
);

  localparam logic [BW_COUNT-1:0] TIMEOUT_VAL = BW_COUNT'(TIMEOUT_COUNT);
  localparam bit                  TIMEOUT_EN  = (TIMEOUT_COUNT != 0);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [BW_COUNT-1:0] counter;
  logic [BW_COUNT-1:0] counter_inc;
  logic                stop_hit;
  logic                timeout_hit;

  // Saturating increment. It is both the next counter value and the delay reported on a stop.
  always_comb begin
    counter_inc = (&counter) ? counter : counter + 1'b1;
  end

  // Next-state decode and the status outputs. A stop takes priority over a timeout in the same cycle.
  always_comb begin
    state_next   = state;
    stop_hit     = 1'b0;
    timeout_hit  = 1'b0;
    busy         = (state != IDLE);
    result_valid = (state == HOLD);
    unique case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (stop) begin
          stop_hit   = 1'b1;
          state_next = HOLD;
        end else if (TIMEOUT_EN && (counter_inc == TIMEOUT_VAL)) begin
          timeout_hit = 1'b1;
          state_next  = HOLD;
        end
      end
      HOLD: begin
        if (result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstnn) state <= IDLE;
    else        state <= state_next;
  end

  // Delay counter. It clears when a start is accepted and counts while in RUN.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      counter <= '0;
    end else if ((state == IDLE) && start) begin
      counter <= '0;
    end else if (state == RUN) begin
      counter <= counter_inc;
    end
  end

  // Result registers. They load on entry to HOLD and hold until the handshake.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      result_delay   <= '0;
      result_timeout <= 1'b0;
    end else if (stop_hit) begin
      result_delay   <= counter_inc;
      result_timeout <= 1'b0;
    end else if (timeout_hit) begin
      result_delay   <= TIMEOUT_VAL;
      result_timeout <= 1'b1;
    end
  end

  // Statistics. Only stop-terminated results update them, and a clear in the same cycle discards the update.
  always_ff @(posedge clk) begin
    if (!rstnn || clear) begin
      min_delay   <= '1;
      max_delay   <= '0;
      num_measure <= '0;
    end else if (stop_hit) begin
      if (counter_inc < min_delay) min_delay <= counter_inc;
      if (counter_inc > max_delay) max_delay <= counter_inc;
      if (!(&num_measure)) num_measure <= num_measure + 1'b1;
    end
  end

endmodule

// File: tb/tb_delay_measurer.sv
// Scoreboard bench for delay_measurer. Stimulus pushes hand-computed results
// into a queue. Per-instance monitors pop and compare on each handshake.
`timescale 1ns/1ps
module tb_delay_measurer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstnn;
  logic        clear;

  logic        m_start, m_stop, m_ready, m_busy, m_valid, m_timeout;
  logic [31:0] m_delay, m_min, m_max;
  logic [15:0] m_num;

  logic        s_start, s_stop, s_ready, s_busy, s_valid, s_timeout;
  logic [3:0]  s_delay, s_min, s_max;
  logic [15:0] s_num;

  delay_measurer #(.BW_COUNT(32), .TIMEOUT_COUNT(50), .BW_NUM(16)) u_main (
    .clk(clk), .rstnn(rstnn), .start(m_start), .stop(m_stop), .clear(clear),
    .busy(m_busy), .result_valid(m_valid), .result_ready(m_ready),
    .result_delay(m_delay), .result_timeout(m_timeout),
    .min_delay(m_min), .max_delay(m_max), .num_measure(m_num)
  );

  delay_measurer #(.BW_COUNT(4), .TIMEOUT_COUNT(0), .BW_NUM(16)) u_sat (
    .clk(clk), .rstnn(rstnn), .start(s_start), .stop(s_stop), .clear(1'b0),
    .busy(s_busy), .result_valid(s_valid), .result_ready(s_ready),
    .result_delay(s_delay), .result_timeout(s_timeout),
    .min_delay(s_min), .max_delay(s_max), .num_measure(s_num)
  );

  typedef struct {
    logic [31:0] d;
    logic        to;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [15:0] num;
  } exp_t;

  exp_t q_main[$];
  exp_t q_sat[$];
  exp_t e_main;
  exp_t e_sat;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, want);
    end
  endtask

  // Main-instance monitor: compare every accepted result against the queue head.
  always @(negedge clk) begin
    if (rstnn === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (q_main.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL main_unexpected_result actual=%0h expected=none", m_delay);
      end else begin
        e_main = q_main.pop_front();
        check("main_delay",   m_delay,            e_main.d);
        check("main_timeout", {31'b0, m_timeout}, {31'b0, e_main.to});
        check("main_min",     m_min,              e_main.mn);
        check("main_max",     m_max,              e_main.mx);
        check("main_num",     {16'b0, m_num},     {16'b0, e_main.num});
      end
    end
  end

  // Saturation-instance monitor.
  always @(negedge clk) begin
    if (rstnn === 1'b1 && s_valid === 1'b1 && s_ready === 1'b1) begin
      if (q_sat.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sat_unexpected_result actual=%0h expected=none", s_delay);
      end else begin
        e_sat = q_sat.pop_front();
        check("sat_delay",   {28'b0, s_delay},   e_sat.d);
        check("sat_timeout", {31'b0, s_timeout}, {31'b0, e_sat.to});
        check("sat_min",     {28'b0, s_min},     e_sat.mn);
        check("sat_max",     {28'b0, s_max},     e_sat.mx);
        check("sat_num",     {16'b0, s_num},     {16'b0, e_sat.num});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv(input bit sat, input logic st, input logic sp);
    if (sat) begin
      s_start = st;
      s_stop  = sp;
    end else begin
      m_start = st;
      m_stop  = sp;
    end
  endtask

  task automatic push(input bit sat, input logic [31:0] d, input logic to,
                      input logic [31:0] mn, input logic [31:0] mx, input logic [15:0] num);
    exp_t e;
    e.d   = d;
    e.to  = to;
    e.mn  = mn;
    e.mx  = mx;
    e.num = num;
    if (sat) q_sat.push_back(e);
    else     q_main.push_back(e);
  endtask

  // One measurement of k cycles, with ready high. with_stop also drives stop together with start.
  task automatic measure(input bit sat, input int k, input bit with_stop, input bit clr,
                         input logic [31:0] d, input logic [31:0] mn, input logic [31:0] mx,
                         input logic [15:0] num);
    drv(sat, 1'b1, with_stop);
    cyc(1);
    drv(sat, 1'b0, 1'b0);
    if (k > 1) cyc(k - 1);
    if (sat) check("sat_busy_run", {31'b0, s_busy}, 32'd1);
    else     check("main_busy_run", {31'b0, m_busy}, 32'd1);
    push(sat, d, 1'b0, mn, mx, num);
    drv(sat, 1'b0, 1'b1);
    clear = clr;
    cyc(1);
    drv(sat, 1'b0, 1'b0);
    clear = 1'b0;
    cyc(1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstnn = 1'b0; clear = 1'b0;
    m_start = 1'b0; m_stop = 1'b0; m_ready = 1'b1;
    s_start = 1'b0; s_stop = 1'b0; s_ready = 1'b1;
    cyc(3);
    check("rst_busy",    {31'b0, m_busy},    32'd0);
    check("rst_valid",   {31'b0, m_valid},   32'd0);
    check("rst_delay",   m_delay,            32'd0);
    check("rst_timeout", {31'b0, m_timeout}, 32'd0);
    check("rst_min",     m_min,              32'hFFFF_FFFF);
    check("rst_max",     m_max,              32'd0);
    check("rst_num",     {16'b0, m_num},     32'd0);
    rstnn = 1'b1;
    cyc(5);

    // 4-bit counter, delay 20 saturates at 15
    measure(1'b1, 20, 1'b0, 1'b0, 32'd15, 32'd15, 32'd15, 16'd1);

    measure(1'b0, 3, 1'b0, 1'b0, 32'd3, 32'd3, 32'd3, 16'd1);
    measure(1'b0, 1, 1'b0, 1'b0, 32'd1, 32'd1, 32'd3, 16'd2);
    // start with stop in IDLE: stop ignored, stays in RUN until a later stop
    measure(1'b0, 30, 1'b1, 1'b0, 32'd30, 32'd1, 32'd30, 16'd3);

    // Backpressure: result held for 20 cycles while start/stop toggle
    m_ready = 1'b0;
    drv(1'b0, 1'b1, 1'b0);
    cyc(1);
    drv(1'b0, 1'b0, 1'b0);
    cyc(2);
    push(1'b0, 32'd3, 1'b0, 32'd1, 32'd30, 16'd4);
    drv(1'b0, 1'b0, 1'b1);
    cyc(1);
    for (int i = 0; i < 20; i++) begin
      drv(1'b0, i[0], ~i[0]);
      cyc(1);
      check("hold_valid", {31'b0, m_valid}, 32'd1);
      check("hold_delay", m_delay, 32'd3);
    end
    drv(1'b0, 1'b0, 1'b0);
    cyc(1);
    // start on the handshake cycle is ignored. Held high, it is accepted on the next cycle.
    m_ready = 1'b1;
    m_start = 1'b1;
    cyc(1);
    cyc(1);
    m_start = 1'b0;
    cyc(3);
    push(1'b0, 32'd4, 1'b0, 32'd1, 32'd30, 16'd5);
    m_stop = 1'b1;
    cyc(1);
    m_stop = 1'b0;
    cyc(1);

    // Timeout at 50 with no stop: statistics unchanged
    drv(1'b0, 1'b1, 1'b0);
    cyc(1);
    drv(1'b0, 1'b0, 1'b0);
    push(1'b0, 32'd50, 1'b1, 32'd1, 32'd30, 16'd5);
    cyc(52);
    check("timeout_idle", {31'b0, m_busy}, 32'd0);
    check("timeout_num",  {16'b0, m_num},  32'd5);
    // Stop exactly at the timeout cycle: stop wins
    measure(1'b0, 50, 1'b0, 1'b0, 32'd50, 32'd1, 32'd50, 16'd6);

    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clear_min", m_min,          32'hFFFF_FFFF);
    check("clear_max", m_max,          32'd0);
    check("clear_num", {16'b0, m_num}, 32'd0);

    measure(1'b0, 7,  1'b0, 1'b0, 32'd7,  32'd7, 32'd7,  16'd1);
    measure(1'b0, 2,  1'b0, 1'b0, 32'd2,  32'd2, 32'd7,  16'd2);
    measure(1'b0, 12, 1'b0, 1'b0, 32'd12, 32'd2, 32'd12, 16'd3);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    // clear coincident with the update when 9 enters HOLD
    measure(1'b0, 9, 1'b0, 1'b1, 32'd9, 32'hFFFF_FFFF, 32'd0, 16'd0);

    // Reset mid-RUN aborts without a result
    drv(1'b0, 1'b1, 1'b0);
    cyc(1);
    drv(1'b0, 1'b0, 1'b0);
    cyc(5);
    rstnn = 1'b0;
    cyc(1);
    check("rstrun_busy",  {31'b0, m_busy},  32'd0);
    check("rstrun_valid", {31'b0, m_valid}, 32'd0);
    check("rstrun_num",   {16'b0, m_num},   32'd0);
    check("rstrun_min",   m_min,            32'hFFFF_FFFF);
    rstnn = 1'b1;
    cyc(10);
    check("rstrun_idle", {31'b0, m_busy}, 32'd0);

    check("main_queue_drained", 32'(q_main.size()), 32'd0);
    check("sat_queue_drained",  32'(q_sat.size()),  32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
